sc_regbank_writer: RTL and testbench

SC_REGBANK_WRITER -- requirements
Module: sc_regbank_writer

---
 rtl/sc_regbank_writer_if.sv | 44 ++++
 rtl/sc_regbank_writer.sv | 121 ++++++++++++
 tb/tb_sc_regbank_writer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sc_regbank_writer_if.sv
// Request/strobe bundle between a register-bank controller and its writer.
// The master issues requests and observes strobes; the writer is the slave.
interface sc_regbank_writer_if #(
   parameter int DATAWIDTH_BUS = 32,
   parameter int NUM_REGS      = 8,
   parameter int ADDRWIDTH     = 3
);
   logic                     sc_regbank_writer_req_InHigh;
   logic [1:0]               sc_regbank_writer_op_InBus;
   logic [ADDRWIDTH-1:0]     sc_regbank_writer_addr_InBus;
   logic [DATAWIDTH_BUS-1:0] sc_regbank_writer_data_InBus;
   logic [NUM_REGS-1:0]      sc_regbank_writer_load_OutBusLow;
   logic [NUM_REGS-1:0]      sc_regbank_writer_clear_OutBusLow;
   logic [DATAWIDTH_BUS-1:0] sc_regbank_writer_data_OutBus;
   logic                     sc_regbank_writer_busy_OutHigh;
   logic                     sc_regbank_writer_ack_OutHigh;
   logic                     sc_regbank_writer_error_OutHigh;

   modport master (
      output sc_regbank_writer_req_InHigh,
      output sc_regbank_writer_op_InBus,
      output sc_regbank_writer_addr_InBus,
      output sc_regbank_writer_data_InBus,
      input  sc_regbank_writer_load_OutBusLow,
      input  sc_regbank_writer_clear_OutBusLow,
      input  sc_regbank_writer_data_OutBus,
      input  sc_regbank_writer_busy_OutHigh,
      input  sc_regbank_writer_ack_OutHigh,
      input  sc_regbank_writer_error_OutHigh
   );

   modport slave (
      input  sc_regbank_writer_req_InHigh,
      input  sc_regbank_writer_op_InBus,
      input  sc_regbank_writer_addr_InBus,
      input  sc_regbank_writer_data_InBus,
      output sc_regbank_writer_load_OutBusLow,
      output sc_regbank_writer_clear_OutBusLow,
      output sc_regbank_writer_data_OutBus,
      output sc_regbank_writer_busy_OutHigh,
      output sc_regbank_writer_ack_OutHigh,
      output sc_regbank_writer_error_OutHigh
   );
endinterface

// File: rtl/sc_regbank_writer.sv
// Register-bank writer: turns single write/clear/clear-all requests into
// active-low per-register load/clear strobes, with a one-cycle ack/error.
module sc_regbank_writer #(
   parameter int DATAWIDTH_BUS = 32,
   parameter int NUM_REGS      = 8,
   parameter int ADDRWIDTH     = 3
) (
   input logic               sc_regbank_writer_CLOCK_50,
   input logic               sc_regbank_writer_RESET_InHigh,
   sc_regbank_writer_if.slave bus
);
   localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [NUM_REGS-1:0] ALL_ONES  = '1;
   localparam logic [IDXW-1:0]     LAST_IDX  = IDXW'(NUM_REGS - 1);

   typedef enum logic [1:0] {IDLE, STROBE, SWEEP, ACK} state_t;

   state_t                   stateReg;
   logic [IDXW-1:0]          indexReg;
   logic [NUM_REGS-1:0]      loadReg;
   logic [NUM_REGS-1:0]      clearReg;
   logic [DATAWIDTH_BUS-1:0] dataReg;
   logic                     busyReg;
   logic                     ackReg;
   logic                     errorReg;

   logic [NUM_REGS-1:0]      addrHot;
   logic [NUM_REGS-1:0]      sweepNextHot;
   logic [IDXW-1:0]          indexNext;
   logic                     addrValid;
   logic                     opIsError;

   assign indexNext = indexReg + IDXW'(1);
   assign addrValid = (32'(bus.sc_regbank_writer_addr_InBus) < 32'(NUM_REGS));
   // Reserved opcode, or a single-register op aimed past the bank.
   assign opIsError = (bus.sc_regbank_writer_op_InBus == 2'b11) ||
                      (!bus.sc_regbank_writer_op_InBus[1] && !addrValid);

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
         assign addrHot[gi]      = (bus.sc_regbank_writer_addr_InBus == ADDRWIDTH'(gi));
         assign sweepNextHot[gi] = (indexNext == IDXW'(gi));
      end
   endgenerate

   always_ff @(posedge sc_regbank_writer_CLOCK_50 or posedge sc_regbank_writer_RESET_InHigh) begin
      if (sc_regbank_writer_RESET_InHigh) begin
         stateReg <= IDLE;
         indexReg <= '0;
         loadReg  <= ALL_ONES;
         clearReg <= ALL_ONES;
         dataReg  <= '0;
         busyReg  <= 1'b0;
         ackReg   <= 1'b0;
         errorReg <= 1'b0;
      end else begin
         case (stateReg)
            IDLE: begin
               ackReg   <= 1'b0;
               errorReg <= 1'b0;
               if (bus.sc_regbank_writer_req_InHigh) begin
                  busyReg <= 1'b1;
                  if (opIsError) begin
                     stateReg <= ACK;
                     ackReg   <= 1'b1;
                     errorReg <= 1'b1;
                  end else begin
                     case (bus.sc_regbank_writer_op_InBus)
                        2'b00: begin
                           stateReg <= STROBE;
                           loadReg  <= ~addrHot;
                           dataReg  <= bus.sc_regbank_writer_data_InBus;
                        end
                        2'b01: begin
                           stateReg <= STROBE;
                           clearReg <= ~addrHot;
                        end
                        default: begin
                           stateReg <= SWEEP;
                           indexReg <= '0;
                           clearReg <= ~NUM_REGS'(1);
                        end
                     endcase
                  end
               end
            end
            STROBE: begin
               loadReg  <= ALL_ONES;
               clearReg <= ALL_ONES;
               stateReg <= ACK;
               ackReg   <= 1'b1;
            end
            SWEEP: begin
               // The index stops at the last register rather than wrapping.
               if (indexReg == LAST_IDX) begin
                  clearReg <= ALL_ONES;
                  stateReg <= ACK;
                  ackReg   <= 1'b1;
               end else begin
                  indexReg <= indexNext;
                  clearReg <= ~sweepNextHot;
               end
            end
            ACK: begin
               ackReg   <= 1'b0;
               errorReg <= 1'b0;
               busyReg  <= 1'b0;
               stateReg <= IDLE;
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign bus.sc_regbank_writer_load_OutBusLow  = loadReg;
   assign bus.sc_regbank_writer_clear_OutBusLow = clearReg;
   assign bus.sc_regbank_writer_data_OutBus     = dataReg;
   assign bus.sc_regbank_writer_busy_OutHigh    = busyReg;
   assign bus.sc_regbank_writer_ack_OutHigh     = ackReg;
   assign bus.sc_regbank_writer_error_OutHigh   = errorReg;
endmodule

// File: tb/tb_sc_regbank_writer.sv
// Scoreboard bench for sc_regbank_writer: stimulus queues per-busy-cycle strobe
// expectations and per-ack responses; a negedge monitor pops and compares.
module tb_sc_regbank_writer;
   logic clk;
   logic rst;

   sc_regbank_writer_if #(.DATAWIDTH_BUS(32), .NUM_REGS(8), .ADDRWIDTH(4)) bus ();

   sc_regbank_writer #(.DATAWIDTH_BUS(32), .NUM_REGS(8), .ADDRWIDTH(4)) dut (
      .sc_regbank_writer_CLOCK_50     (clk),
      .sc_regbank_writer_RESET_InHigh (rst),
      .bus                            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  load, clear;
   logic [31:0] dout;
   logic        busy, ack, err;
   assign load  = bus.sc_regbank_writer_load_OutBusLow;
   assign clear = bus.sc_regbank_writer_clear_OutBusLow;
   assign dout  = bus.sc_regbank_writer_data_OutBus;
   assign busy  = bus.sc_regbank_writer_busy_OutHigh;
   assign ack   = bus.sc_regbank_writer_ack_OutHigh;
   assign err   = bus.sc_regbank_writer_error_OutHigh;

   typedef struct { logic [7:0] load; logic [7:0] clear; logic ack; } cyc_t;
   typedef struct { logic err; logic [31:0] data; } resp_t;

   cyc_t  cycQ[$];
   resp_t respQ[$];
   cyc_t  monC;
   resp_t monR;
   logic [31:0] expData;
   int passCnt  = 0;
   int checkCnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCnt++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
      else passCnt++;
   endtask

   // Expected busy-cycle strobes and the ack response for one accepted request.
   task automatic pushExpect(input logic [1:0] o, input logic [3:0] a, input logic [31:0] d);
      cyc_t  c;
      resp_t r;
      if (o == 2'b10) begin
         for (int i = 0; i < 8; i++) begin
            c.load = 8'hFF; c.clear = ~(8'h01 << i); c.ack = 1'b0;
            cycQ.push_back(c);
         end
      end else if (o != 2'b11 && a < 4'd8) begin
         c.load  = (o == 2'b00) ? ~(8'h01 << a) : 8'hFF;
         c.clear = (o == 2'b01) ? ~(8'h01 << a) : 8'hFF;
         c.ack   = 1'b0;
         cycQ.push_back(c);
         if (o == 2'b00) expData = d;
      end
      c.load = 8'hFF; c.clear = 8'hFF; c.ack = 1'b1;
      cycQ.push_back(c);
      r.err  = (o == 2'b11) || (o != 2'b10 && a >= 4'd8);
      r.data = expData;
      respQ.push_back(r);
   endtask

   task automatic waitIdle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checkCnt++;
         $display("FAIL idle_timeout busy=%0d required=0", busy);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] o, input logic [3:0] a, input logic [31:0] d);
      bus.sc_regbank_writer_req_InHigh = r;
      bus.sc_regbank_writer_op_InBus   = o;
      bus.sc_regbank_writer_addr_InBus = a;
      bus.sc_regbank_writer_data_InBus = d;
   endtask

   task automatic doOp(input logic [1:0] o, input logic [3:0] a, input logic [31:0] d);
      pushExpect(o, a, d);
      @(posedge clk); #1 drive(1'b1, o, a, d);
      @(posedge clk); #1 bus.sc_regbank_writer_req_InHigh = 1'b0;
      waitIdle();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            if (cycQ.size() == 0) begin
               checkCnt++;
               $display("FAIL unexpected_busy busy=1 required=0 strobes=%h", {load, clear});
            end else begin
               monC = cycQ.pop_front();
               chk("strobes", {48'h0, load, clear}, {48'h0, monC.load, monC.clear});
               chk("ack_timing", {63'h0, ack}, {63'h0, monC.ack});
            end
         end else begin
            chk("idle_quiet", {47'h0, load, clear, ack}, {47'h0, 16'hFFFF, 1'b0});
         end
         chk("strobe_at_most_one", {63'h0, ($countones(~{load, clear}) <= 1)}, 64'h1);
         if (ack) begin
            if (respQ.size() == 0) begin
               checkCnt++;
               $display("FAIL unexpected_ack ack=1 required=0");
            end else begin
               monR = respQ.pop_front();
               $display("ack: error=%0d data=%h", err, dout);
               chk("ack_error", {63'h0, err}, {63'h0, monR.err});
               chk("ack_data", {32'h0, dout}, {32'h0, monR.data});
            end
         end
      end
   end

   initial begin
      expData = 32'h0;
      rst = 1'b1;
      drive(1'b0, 2'b00, 4'd0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_strobes", {48'h0, load, clear}, 64'hFFFF);
      chk("rst_data", {32'h0, dout}, 64'h0);
      chk("rst_flags", {61'h0, busy, ack, err}, 64'h0);
      rst = 1'b0;

      doOp(2'b00, 4'd5, 32'hDEADBEEF);
      doOp(2'b01, 4'd2, 32'h13572468);
      doOp(2'b00, 4'd0, 32'h12345678);
      doOp(2'b00, 4'd7, 32'hA5A5A5A5);
      doOp(2'b10, 4'd3, 32'h0BADBAD0);
      doOp(2'b11, 4'd3, 32'hFFFFFFFF);
      doOp(2'b00, 4'd8, 32'h11111111);
      doOp(2'b01, 4'd12, 32'h22222222);
      doOp(2'b01, 4'd7, 32'h33333333);

      // Requests raised during STROBE and ACK must be dropped.
      pushExpect(2'b00, 4'd1, 32'hCAFEF00D);
      @(posedge clk); #1 drive(1'b1, 2'b00, 4'd1, 32'hCAFEF00D);
      @(posedge clk); #1 drive(1'b1, 2'b00, 4'd6, 32'h99999999);
      @(posedge clk);
      @(posedge clk); #1 bus.sc_regbank_writer_req_InHigh = 1'b0;
      waitIdle();
      chk("ignored_req_data", {32'h0, dout}, {32'h0, 32'hCAFEF00D});

      // Req held through two clear-alls: one op per IDLE visit.
      pushExpect(2'b10, 4'd0, 32'h0);
      pushExpect(2'b10, 4'd0, 32'h0);
      @(posedge clk); #1 drive(1'b1, 2'b10, 4'd0, 32'h0);
      repeat (20) @(posedge clk);
      #1 bus.sc_regbank_writer_req_InHigh = 1'b0;
      waitIdle();

      // Reset while the sweep sits at index 3.
      pushExpect(2'b10, 4'd0, 32'h0);
      @(posedge clk); #1 drive(1'b1, 2'b10, 4'd0, 32'h0);
      @(posedge clk); #1 bus.sc_regbank_writer_req_InHigh = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("sweep_idx3", {48'h0, load, clear}, {48'h0, 8'hFF, 8'hF7});
      #5 rst = 1'b1;
      cycQ.delete();
      respQ.delete();
      expData = 32'h0;
      #1;
      chk("async_rst_strobes", {48'h0, load, clear}, 64'hFFFF);
      chk("async_rst_busy", {63'h0, busy}, 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("post_rst_busy", {63'h0, busy}, 64'h0);
      chk("post_rst_data", {32'h0, dout}, 64'h0);
      repeat (12) @(posedge clk);

      doOp(2'b00, 4'd3, 32'h0BADF00D);
      repeat (3) @(posedge clk);
      #1;
      chk("cyc_queue_drained", 64'(cycQ.size()), 64'h0);
      chk("resp_queue_drained", 64'(respQ.size()), 64'h0);
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end
endmodule
